// File: rtl/gin_bus_pkg.sv
// Shared definitions for the gin_bus global-input-network block.
//  - Default parameter values for tag/ID width, payload width and lane count.
//  - FSM state encoding for the top-level delivery controller.
package gin_bus_pkg;

  localparam int DEF_ID_BITWIDTH     = 4;
  localparam int DEF_PACKET_BITWIDTH = 8;
  localparam int DEF_SLV_NUM         = 6;

  typedef enum logic {
    GIN_IDLE    = 1'b0,
    GIN_DELIVER = 1'b1
  } gin_state_e;

endpackage

// File: rtl/gin_bus_if.sv
// Bus interface for gin_bus: one tagged upstream stream, SLV_NUM downstream lanes and the
// per-lane ID configuration load.
//  i_packet/i_tag/i_valid/o_ready : upstream (GLB side) valid/ready stream
//  o_packet/o_valid/i_ready       : per-lane payload fan-out, lane k at [k*PACKET_BITWIDTH +: PACKET_BITWIDTH]
//  i_id/i_id_valid                : per-lane ID load from the config scan chain
//  o_nomatch                      : one-cycle pulse when an accepted packet matched no lane
// Modport slave is the gin_bus side; master is the GLB/PE/config environment side.
interface gin_bus_if
  import gin_bus_pkg::*;
#(
  parameter int ID_BITWIDTH     = DEF_ID_BITWIDTH,
  parameter int PACKET_BITWIDTH = DEF_PACKET_BITWIDTH,
  parameter int SLV_NUM         = DEF_SLV_NUM
) ();

  logic [PACKET_BITWIDTH-1:0]         i_packet;
  logic [ID_BITWIDTH-1:0]             i_tag;
  logic                               i_valid;
  logic                               o_ready;
  logic [SLV_NUM*PACKET_BITWIDTH-1:0] o_packet;
  logic [SLV_NUM-1:0]                 o_valid;
  logic [SLV_NUM-1:0]                 i_ready;
  logic [SLV_NUM*ID_BITWIDTH-1:0]     i_id;
  logic                               i_id_valid;
  logic                               o_nomatch;

  modport slave (
    input  i_packet, i_tag, i_valid, i_ready, i_id, i_id_valid,
    output o_ready, o_packet, o_valid, o_nomatch
  );

  modport master (
    output i_packet, i_tag, i_valid, i_ready, i_id, i_id_valid,
    input  o_ready, o_packet, o_valid, o_nomatch
  );

endinterface

// File: rtl/gin_bus_id_match.sv
// Per-lane ID register and tag comparator for gin_bus.
//  clk, rst   : clock, asynchronous active-high reset
//  id_valid_i : load id_i into the lane ID register at the next edge
//  id_i       : this lane's ID from the config scan chain
//  tag_i      : destination tag of the current upstream packet
//  match_o    : tag_i equals the stored (pre-load) lane ID
module gin_id_match
  import gin_bus_pkg::*;
#(
  parameter int ID_BITWIDTH = DEF_ID_BITWIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid_i,
  input  logic [ID_BITWIDTH-1:0] id_i,
  input  logic [ID_BITWIDTH-1:0] tag_i,
  output logic                   match_o
);

  logic [ID_BITWIDTH-1:0] id_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; that is what lets a same-cycle ID load leave the match on the old ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             id_q <= '0;
    else if (id_valid_i) id_q <= id_i;
  end

  assign match_o = (tag_i == id_q);

endmodule

// File: rtl/gin_bus.sv
// gin_bus: GLB->PE global input network bus. Multicasts each accepted upstream packet to
// every lane whose configured ID equals the packet tag; each lane completes its own
// valid/ready handshake and upstream sees a single ready.
//  i_clk : clock (single domain)
//  i_rst : asynchronous active-high reset; clears IDs, config-done, FSM and in-flight packet
//  bus   : gin_bus_if slave modport (upstream stream, lane fan-out, ID load, nomatch pulse)
module gin_bus
  import gin_bus_pkg::*;
#(
  parameter int ID_BITWIDTH     = DEF_ID_BITWIDTH,
  parameter int PACKET_BITWIDTH = DEF_PACKET_BITWIDTH,
  parameter int SLV_NUM         = DEF_SLV_NUM
) (
  input logic     i_clk,
  input logic     i_rst,
  gin_bus_if.slave bus
);

  gin_state_e                 state_q, state_d;
  logic                       cfg_done_q, cfg_done_d;
  logic [SLV_NUM-1:0]         pending_q, pending_d;
  logic [PACKET_BITWIDTH-1:0] data_q, data_d;
  logic                       nomatch_q, nomatch_d;
  logic [SLV_NUM-1:0]         match;
  logic                       ready;
  logic                       accept;

  for (genvar k = 0; k < SLV_NUM; k++) begin : g_lane
    gin_id_match #(
      .ID_BITWIDTH (ID_BITWIDTH)
    ) u_id_match (
      .clk        (i_clk),
      .rst        (i_rst),
      .id_valid_i (bus.i_id_valid),
      .id_i       (bus.i_id[k*ID_BITWIDTH +: ID_BITWIDTH]),
      .tag_i      (bus.i_tag),
      .match_o    (match[k])
    );
  end

  // Last-beat bypass: in DELIVER a new packet may be accepted in the same cycle the final
  // outstanding lanes handshake, which keeps throughput at one packet per cycle.
  always_comb begin
    ready = 1'b0;
    if (cfg_done_q) begin
      if (state_q == GIN_IDLE) ready = 1'b1;
      else                     ready = ((pending_q & ~bus.i_ready) == '0);
    end
  end

  assign accept = bus.i_valid && ready;

  // NOTE: every variable is given a default before the case so no path can leave one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    data_d     = data_q;
    nomatch_d  = 1'b0;
    cfg_done_d = cfg_done_q | bus.i_id_valid;

    // Lanes that handshake this cycle drop out of the outstanding mask.
    if (state_q == GIN_DELIVER) pending_d = pending_q & ~bus.i_ready;

    if (accept) begin
      data_d    = bus.i_packet;
      pending_d = match;
      nomatch_d = (match == '0);
      state_d   = (match != '0) ? GIN_DELIVER : GIN_IDLE;
    end else if (state_q == GIN_DELIVER && pending_d == '0) begin
      state_d = GIN_IDLE;
    end
  end

  // NOTE: the payload register is reset along with the control state so o_packet is
  // deterministic out of reset; it is a single register, not a memory.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= GIN_IDLE;
      cfg_done_q <= 1'b0;
      pending_q  <= '0;
      data_q     <= '0;
      nomatch_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_done_q <= cfg_done_d;
      pending_q  <= pending_d;
      data_q     <= data_d;
      nomatch_q  <= nomatch_d;
    end
  end

  // o_valid comes straight from pending_q, so an asynchronous reset drops it immediately.
  assign bus.o_valid   = (state_q == GIN_DELIVER) ? pending_q : '0;
  assign bus.o_packet  = {SLV_NUM{data_q}};
  assign bus.o_ready   = ready;
  assign bus.o_nomatch = nomatch_q;

endmodule

// File: tb/tb_gin_bus.sv
module tb_gin_bus;

  localparam int IDW = 4;
  localparam int PW  = 8;
  localparam int SN  = 6;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  gin_bus_if #(.ID_BITWIDTH(IDW), .PACKET_BITWIDTH(PW), .SLV_NUM(SN)) bus ();

  gin_bus #(
    .ID_BITWIDTH     (IDW),
    .PACKET_BITWIDTH (PW),
    .SLV_NUM         (SN)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Inputs are driven at the falling edge; outputs are sampled 1 time unit later.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_ids(input logic [SN*IDW-1:0] ids);
    bus.i_id       = ids;
    bus.i_id_valid = 1'b1;
    tick();
    bus.i_id_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst            = 1'b1;
    bus.i_valid    = 1'b1;
    bus.i_tag      = 4'h0;
    bus.i_packet   = 8'h00;
    bus.i_ready    = '0;
    bus.i_id       = '0;
    bus.i_id_valid = 1'b0;
    @(negedge clk);
    #1;
    total++; if (bus.o_ready !== 1'b0)  begin bad++; $display("FAIL reset_ready got=%b want=0", bus.o_ready); end
    total++; if (bus.o_valid !== 6'h00) begin bad++; $display("FAIL reset_valid got=%b want=000000", bus.o_valid); end
    total++; if (bus.o_packet !== 48'h0) begin bad++; $display("FAIL reset_packet got=%h want=0", bus.o_packet); end
    total++; if (bus.o_nomatch !== 1'b0) begin bad++; $display("FAIL reset_nomatch got=%b want=0", bus.o_nomatch); end
    rst = 1'b0;
    tick(); tick();
    #1;
    total++; if (bus.o_ready !== 1'b0)  begin bad++; $display("FAIL unconfigured_ready got=%b want=0", bus.o_ready); end
    total++; if (bus.o_valid !== 6'h00) begin bad++; $display("FAIL unconfigured_valid got=%b want=000000", bus.o_valid); end
    // Load ids {0..5}; i_valid is still high but o_ready is 0 so nothing is accepted.
    bus.i_id       = 24'h543210;
    bus.i_id_valid = 1'b1;
    #1;
    total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL load_cycle_ready got=%b want=0", bus.o_ready); end
    tick();
    bus.i_id_valid = 1'b0;
    bus.i_valid    = 1'b0;
    #1;
    total++; if (bus.o_ready !== 1'b1)  begin bad++; $display("FAIL configured_ready got=%b want=1", bus.o_ready); end
    total++; if (bus.o_valid !== 6'h00) begin bad++; $display("FAIL configured_valid got=%b want=000000", bus.o_valid); end
  endtask

  task automatic test_unicast;
    bus.i_tag    = 4'h3;
    bus.i_packet = 8'hA5;
    bus.i_valid  = 1'b1;
    bus.i_ready  = '0;
    #1;
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL uni_accept_ready got=%b want=1", bus.o_ready); end
    tick();
    bus.i_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (bus.o_valid !== 6'b001000) begin bad++; $display("FAIL uni_hold_valid cyc=%0d got=%b want=001000", c, bus.o_valid); end
      total++; if (bus.o_packet[3*PW +: PW] !== 8'hA5) begin bad++; $display("FAIL uni_hold_data cyc=%0d got=%h want=a5", c, bus.o_packet[3*PW +: PW]); end
      total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL uni_hold_ready cyc=%0d got=%b want=0", c, bus.o_ready); end
      tick();
    end
    bus.i_ready = 6'b001000;
    #1;
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL uni_bypass_ready got=%b want=1", bus.o_ready); end
    tick();
    bus.i_ready = '0;
    #1;
    total++; if (bus.o_valid !== 6'h00) begin bad++; $display("FAIL uni_drained_valid got=%b want=000000", bus.o_valid); end
    total++; if (bus.o_ready !== 1'b1)  begin bad++; $display("FAIL uni_drained_ready got=%b want=1", bus.o_ready); end
  endtask

  task automatic test_multicast;
    // ids lane0..5 = {0,0,1,2,2,2}
    load_ids(24'h222100);
    bus.i_tag    = 4'h2;
    bus.i_packet = 8'h3C;
    bus.i_valid  = 1'b1;
    bus.i_ready  = '0;
    tick();                                   // edge N
    bus.i_tag    = 4'h0;                      // next packet waits upstream
    bus.i_packet = 8'h11;
    bus.i_ready  = 6'b001000;                 // cycle N+1: lane3 ready
    #1;
    total++; if (bus.o_valid !== 6'b111000) begin bad++; $display("FAIL multi_n1_valid got=%b want=111000", bus.o_valid); end
    total++; if (bus.o_packet !== {6{8'h3C}}) begin bad++; $display("FAIL multi_n1_data got=%h want=3c x6", bus.o_packet); end
    total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL multi_n1_ready got=%b want=0", bus.o_ready); end
    tick();
    bus.i_ready = 6'b100000;                  // cycle N+2: lane5 ready
    #1;
    total++; if (bus.o_valid !== 6'b110000) begin bad++; $display("FAIL multi_n2_valid got=%b want=110000", bus.o_valid); end
    total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL multi_n2_ready got=%b want=0", bus.o_ready); end
    tick();
    bus.i_ready = '0;                         // cycle N+3: nobody ready
    #1;
    total++; if (bus.o_valid !== 6'b010000) begin bad++; $display("FAIL multi_n3_valid got=%b want=010000", bus.o_valid); end
    total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL multi_n3_ready got=%b want=0", bus.o_ready); end
    tick();
    bus.i_ready = 6'b010000;                  // cycle N+4: lane4 ready, next packet accepted
    #1;
    total++; if (bus.o_valid !== 6'b010000) begin bad++; $display("FAIL multi_n4_valid got=%b want=010000", bus.o_valid); end
    total++; if (bus.o_packet[4*PW +: PW] !== 8'h3C) begin bad++; $display("FAIL multi_n4_data got=%h want=3c", bus.o_packet[4*PW +: PW]); end
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL multi_n4_ready got=%b want=1", bus.o_ready); end
    tick();
    bus.i_valid = 1'b0;
    bus.i_ready = '0;
    #1;
    total++; if (bus.o_valid !== 6'b000011) begin bad++; $display("FAIL multi_next_valid got=%b want=000011", bus.o_valid); end
    total++; if (bus.o_packet[0 +: PW] !== 8'h11) begin bad++; $display("FAIL multi_next_data got=%h want=11", bus.o_packet[0 +: PW]); end
    bus.i_ready = 6'h3F;
    tick();
    #1;
    total++; if (bus.o_valid !== 6'h00) begin bad++; $display("FAIL multi_drained_valid got=%b want=000000", bus.o_valid); end
  endtask

  task automatic test_nomatch;
    load_ids(24'h543210);
    bus.i_tag    = 4'h7;
    bus.i_packet = 8'h55;
    bus.i_valid  = 1'b1;
    bus.i_ready  = '0;
    #1;
    total++; if (bus.o_ready !== 1'b1)   begin bad++; $display("FAIL nomatch_accept_ready got=%b want=1", bus.o_ready); end
    total++; if (bus.o_nomatch !== 1'b0) begin bad++; $display("FAIL nomatch_before got=%b want=0", bus.o_nomatch); end
    tick();
    bus.i_valid = 1'b0;
    #1;
    total++; if (bus.o_nomatch !== 1'b1) begin bad++; $display("FAIL nomatch_pulse got=%b want=1", bus.o_nomatch); end
    total++; if (bus.o_valid !== 6'h00)  begin bad++; $display("FAIL nomatch_valid got=%b want=000000", bus.o_valid); end
    total++; if (bus.o_ready !== 1'b1)   begin bad++; $display("FAIL nomatch_ready got=%b want=1", bus.o_ready); end
    tick();
    #1;
    total++; if (bus.o_nomatch !== 1'b0) begin bad++; $display("FAIL nomatch_after got=%b want=0", bus.o_nomatch); end
    total++; if (bus.o_valid !== 6'h00)  begin bad++; $display("FAIL nomatch_after_valid got=%b want=000000", bus.o_valid); end
  endtask

  task automatic test_back_to_back;
    int accepts = 0;
    logic [3:0] tag;
    logic [7:0] pkt;
    logic [5:0] exp_valid;
    bus.i_ready = 6'h3F;
    for (int k = 0; k < 10; k++) begin
      tag          = 4'(k % 6);
      pkt          = 8'(8'h40 + k);
      bus.i_tag    = tag;
      bus.i_packet = pkt;
      bus.i_valid  = 1'b1;
      #1;
      if (bus.o_ready === 1'b1) accepts++;
      tick();
      #1;
      exp_valid = 6'(6'b000001 << tag);
      total++; if (bus.o_valid !== exp_valid) begin bad++; $display("FAIL b2b_valid pkt=%0d got=%b want=%b", k, bus.o_valid, exp_valid); end
      total++; if (bus.o_packet[tag*PW +: PW] !== pkt) begin bad++; $display("FAIL b2b_data pkt=%0d got=%h want=%h", k, bus.o_packet[tag*PW +: PW], pkt); end
    end
    bus.i_valid = 1'b0;
    total++; if (accepts !== 10) begin bad++; $display("FAIL b2b_accepts got=%0d want=10", accepts); end
    tick();
    #1;
    total++; if (bus.o_valid !== 6'h00) begin bad++; $display("FAIL b2b_drained_valid got=%b want=000000", bus.o_valid); end
  endtask

  task automatic test_reset_mid;
    bus.i_tag    = 4'h1;
    bus.i_packet = 8'h9A;
    bus.i_valid  = 1'b1;
    bus.i_ready  = '0;
    tick();
    bus.i_valid = 1'b0;
    #1;
    total++; if (bus.o_valid !== 6'b000010) begin bad++; $display("FAIL rstmid_before_valid got=%b want=000010", bus.o_valid); end
    #1;
    rst = 1'b1;                               // well away from any rising edge
    #1;
    total++; if (bus.o_valid !== 6'h00) begin bad++; $display("FAIL rstmid_async_valid got=%b want=000000", bus.o_valid); end
    total++; if (bus.o_ready !== 1'b0)  begin bad++; $display("FAIL rstmid_async_ready got=%b want=0", bus.o_ready); end
    rst = 1'b0;
    @(negedge clk);
    bus.i_tag    = 4'h4;
    bus.i_packet = 8'hC3;
    bus.i_valid  = 1'b1;
    #1;
    total++; if (bus.o_ready !== 1'b0)  begin bad++; $display("FAIL rstmid_post_ready got=%b want=0", bus.o_ready); end
    tick();
    #1;
    total++; if (bus.o_valid !== 6'h00) begin bad++; $display("FAIL rstmid_post_valid got=%b want=000000", bus.o_valid); end
    load_ids(24'h543210);
    total++; if (bus.o_ready !== 1'b1)  begin bad++; $display("FAIL rstmid_reload_ready got=%b want=1", bus.o_ready); end
    tick();
    bus.i_valid = 1'b0;
    #1;
    total++; if (bus.o_valid !== 6'b010000) begin bad++; $display("FAIL rstmid_deliver_valid got=%b want=010000", bus.o_valid); end
    total++; if (bus.o_packet[4*PW +: PW] !== 8'hC3) begin bad++; $display("FAIL rstmid_deliver_data got=%h want=c3", bus.o_packet[4*PW +: PW]); end
    bus.i_ready = 6'h3F;
    tick();
    #1;
    total++; if (bus.o_valid !== 6'h00) begin bad++; $display("FAIL rstmid_drained_valid got=%b want=000000", bus.o_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_unicast();
    test_multicast();
    test_nomatch();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
